// File: rtl/systemizer_host_port.sv
// rtl/systemizer_host_port.sv - host-side loader/launcher/reader for one systemizer memory port
// Optional ELEMENT_CHECK_EN: flags loaded words containing an element >= M in err_elem.
module systemizer_host_port #(
  parameter int L      = 8,
  parameter int K      = 16,
  parameter int M      = 3,
  parameter int BLOCK  = 4,
  parameter int RD_LAT = 1,
  localparam int E     = $clog2(M),
  localparam int W     = BLOCK * E,
  localparam int DEPTH = L * K / BLOCK,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          abort,
  output logic          busy,
  output logic          result_ok,
  output logic          result_fail,
  output logic          err_elem,
  output logic          sys_wr_en,
  output logic [AW-1:0] sys_wr_addr,
  output logic [W-1:0]  sys_data_in,
  output logic          sys_rd_en,
  output logic [AW-1:0] sys_rd_addr,
  input  logic [W-1:0]  sys_data_out,
  output logic          sys_start,
  input  logic          sys_done,
  input  logic          sys_fail,
  input  logic          sys_success
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_READ, S_FETCH, S_DRAIN
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [1:0]    lat_q, lat_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          ok_q, ok_d, fail_q, fail_d, err_q, err_d;
  logic          elem_bad;

`ifdef ELEMENT_CHECK_EN
  always_comb begin
    elem_bad = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      if (int'(in_data[i*E +: E]) >= M) elem_bad = 1'b1;
    end
  end
`else
  assign elem_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      lat_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ok_q        <= 1'b0;
      fail_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      lat_q       <= lat_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ok_q        <= ok_d;
      fail_q      <= fail_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    lat_d       = lat_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ok_d        = ok_q;
    fail_d      = fail_q;
    err_d       = err_q;
    in_ready    = 1'b0;
    sys_wr_en   = 1'b0;
    sys_wr_addr = '0;
    sys_data_in = '0;
    sys_rd_en   = 1'b0;
    sys_rd_addr = '0;
    sys_start   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_LOAD;
          wcnt_d  = '0;
          ok_d    = 1'b0;
          fail_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        in_ready    = 1'b1;
        sys_wr_addr = wcnt_q;
        sys_data_in = in_data;
        if (in_valid) begin
          sys_wr_en = 1'b1;
          if (elem_bad) err_d = 1'b1;
          if (wcnt_q == LAST) begin
            wcnt_d  = '0;
            state_d = S_START;
          end else begin
            wcnt_d = wcnt_q + AW'(1);
          end
        end
      end
      S_START: begin
        sys_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // Fail dominates; a done with neither status bit is treated as a failure too.
        if (sys_done) begin
          if (sys_fail || !sys_success) begin
            fail_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ok_d    = 1'b1;
            rcnt_d  = '0;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        sys_rd_en   = 1'b1;
        sys_rd_addr = rcnt_q;
        lat_d       = '0;
        state_d     = S_FETCH;
      end
      S_FETCH: begin
        if (lat_q == 2'(RD_LAT - 1)) begin
          out_data_d  = sys_data_out;
          out_valid_d = 1'b1;
          state_d     = S_DRAIN;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
          if (rcnt_q == LAST) begin
            rcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            rcnt_d  = rcnt_q + AW'(1);
            state_d = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything except the sticky status, which reports the last completed run.
    if (abort) begin
      state_d     = S_IDLE;
      wcnt_d      = '0;
      rcnt_d      = '0;
      lat_d       = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      ok_d        = ok_q;
      fail_d      = fail_q;
      err_d       = err_q;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign result_ok   = ok_q;
  assign result_fail = fail_q;
  assign err_elem    = err_q;

endmodule

// File: tb/tb_systemizer_host_port.sv
// tb/tb_systemizer_host_port.sv - self-checking bench for systemizer_host_port
module tb_systemizer_host_port;

`ifdef ELEMENT_CHECK_EN
  localparam bit ELEM_EN = 1'b1;
`else
  localparam bit ELEM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       abort = 1'b0;
  logic       busy, result_ok, result_fail, err_elem;
  logic       sys_wr_en, sys_rd_en, sys_start;
  logic [4:0] sys_wr_addr, sys_rd_addr;
  logic [7:0] sys_data_in;
  logic [7:0] sys_data_out = '0;
  logic       sys_done = 1'b0, sys_fail = 1'b0, sys_success = 1'b0;

  systemizer_host_port dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .abort(abort),
    .busy(busy), .result_ok(result_ok), .result_fail(result_fail), .err_elem(err_elem),
    .sys_wr_en(sys_wr_en), .sys_wr_addr(sys_wr_addr), .sys_data_in(sys_data_in),
    .sys_rd_en(sys_rd_en), .sys_rd_addr(sys_rd_addr), .sys_data_out(sys_data_out),
    .sys_start(sys_start), .sys_done(sys_done), .sys_fail(sys_fail), .sys_success(sys_success)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic bit bad_word(input logic [7:0] w);
    bit b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] f = w[2*i +: 2];
      if (int'(f) >= 3) b = 1'b1;
    end
    return b;
  endfunction

  // Systemizer memory model: reads return addr*3 one cycle after sys_rd_en.
  always @(posedge clk) begin
    if (sys_rd_en) sys_data_out <= 8'(sys_rd_addr * 3);
  end

  // Reference model state: words the host was told to load, and what the port must produce.
  logic [7:0] words [32];
  logic [7:0] got   [32];
  int load_id = 0;
  int seen_id = 0;
  int cyc = 0, exp_waddr = 0, wr_count = 0, last_wr_cyc = 0;
  int starts = 0, rd_count = 0, out_count = 0, first_addr = -1;
  bit exp_err = 1'b0, hold_prev = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (load_id != seen_id) begin
      seen_id = load_id; exp_waddr = 0; wr_count = 0; starts = 0;
      rd_count = 0; out_count = 0; first_addr = -1; hold_prev = 1'b0;
    end
    if (!rst) begin
      if (sys_wr_en) begin
        if (wr_count == 0) begin exp_err = 1'b0; first_addr = int'(sys_wr_addr); end
        chk("wr_addr", sys_wr_addr, exp_waddr);
        chk("wr_data", sys_data_in, words[exp_waddr % 32]);
        chk("err_elem_load", err_elem, exp_err);
        if (ELEM_EN && bad_word(sys_data_in)) exp_err = 1'b1;
        exp_waddr++; wr_count++; last_wr_cyc = cyc;
      end
      if (sys_start) begin
        chk("start_gap", cyc - last_wr_cyc, 1);
        chk("start_after_words", wr_count, 32);
        starts++;
      end
      if (sys_rd_en) rd_count++;
      if (hold_prev) begin
        chk("out_hold_valid", out_valid, 1'b1);
        chk("out_hold_data", out_data, prev_data);
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
      if (out_valid && out_ready) begin
        chk("out_data", out_data, 8'(out_count * 3));
        if (out_count < 32) got[out_count] = out_data;
        out_count++;
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  function automatic logic [63:0] outs_vec();
    return {in_ready, out_data, out_valid, busy, result_ok, result_fail, err_elem,
            sys_wr_en, sys_wr_addr, sys_data_in, sys_rd_en, sys_rd_addr, sys_start};
  endfunction

  task automatic do_load(input int n, input int abort_at);
    int idx = 0;
    int guard = 0;
    logic acc;
    in_data = words[0];
    in_valid = 1'b1;
    while (idx < n && guard < 400) begin
      if (idx == abort_at) abort = 1'b1;
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; guard++;
      if (abort) begin
        abort = 1'b0; in_valid = 1'b0; in_data = '0;
        return;
      end
      if (acc) begin
        idx++;
        in_data = (idx < n) ? words[idx] : 8'h00;
      end
    end
    in_valid = 1'b0; in_data = '0;
    chk("load_accepted", idx, n);
  endtask

  task automatic run_sys(input logic f, input logic s);
    int g = 0;
    while (starts == 0 && g < 20) begin @(posedge clk); #1; g++; end
    chk("start_seen", starts, 1);
    repeat (10) @(posedge clk);
    #1; sys_done = 1'b1; sys_fail = f; sys_success = s;
    @(posedge clk); #1; sys_done = 1'b0; sys_fail = 1'b0; sys_success = 1'b0;
  endtask

  task automatic do_abort();
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_vec(), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", outs_vec(), 64'd0);

    // Load 0x00..0x1F, success, readback addr*3 with 50% out_ready
    for (int i = 0; i < 32; i++) words[i] = 8'(i);
    load_id++;
    do_load(32, -1);
    run_sys(1'b0, 1'b1);
    g = 0;
    while (out_count < 32 && g < 1000) begin @(posedge clk); #1; out_ready = ~out_ready; g++; end
    out_ready = 1'b0;
    chk("drain_count", out_count, 32);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ok_result_ok", result_ok, 1'b1);
    chk("ok_result_fail", result_fail, 1'b0);
    chk("ok_busy", busy, 1'b0);
    chk("ok_rd_count", rd_count, 32);
    chk("ok_first_word", got[0], 8'h00);
    chk("ok_second_word", got[1], 8'h03);
    chk("ok_last_word", got[31], 8'h5D);
    chk("ok_err_elem", err_elem, ELEM_EN);

    // Fail and success together: fail wins, no readback
    load_id++;
    do_load(32, -1);
    run_sys(1'b1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("fail_result_fail", result_fail, 1'b1);
    chk("fail_result_ok", result_ok, 1'b0);
    chk("fail_no_read", rd_count, 0);
    chk("fail_busy", busy, 1'b0);

    // Done with no status bit is a failure
    load_id++;
    do_load(32, -1);
    run_sys(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done_only_fail", {result_ok, result_fail}, 2'b01);
    chk("done_only_no_read", rd_count, 0);

    // Abort at word 17, then a fresh load restarts at address 0
    load_id++;
    do_load(32, 17);
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_writes", wr_count, 18);
    chk("abort_no_start", starts, 0);
    load_id++;
    do_load(32, -1);
    chk("restart_first_addr", first_addr, 0);
    run_sys(1'b1, 1'b0);
    repeat (3) @(posedge clk);

    // Out-of-range element at address 5
    for (int i = 0; i < 32; i++) words[i] = 8'h00;
    words[5] = 8'hC0;
    load_id++;
    do_load(32, -1);
    @(negedge clk);
    chk("elem_err_after_load", err_elem, ELEM_EN);
    chk("elem_load_complete", wr_count, 32);
    do_abort();
    @(negedge clk);
    chk("elem_err_sticky_abort", err_elem, ELEM_EN);
    chk("elem_abort_busy", busy, 1'b0);

    // Asynchronous reset in the middle of a load
    for (int i = 0; i < 32; i++) words[i] = 8'h11;
    load_id++;
    in_data = 8'h11; in_valid = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("async_reset_outputs", outs_vec(), 64'd0);
    in_valid = 1'b0; in_data = '0;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_no_write", sys_wr_en, 1'b0);
      chk("post_reset_busy", busy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
